iter_divider: RTL and testbench

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/div_pkg.sv | 10 +
 rtl/div_step.sv | 19 +
 rtl/iter_divider.sv | 112 +++++++++++
 tb/tb_iter_divider.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared widths, constants, state type and magnitude helper for iter_divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUOT = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;
  function automatic logic [DIV_WIDTH-1:0] mag(input logic [DIV_WIDTH-1:0] v, input logic sgn);
    return (sgn && v[DIV_WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration using a 33-bit compare/subtract.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic [DIV_WIDTH-1:0] quo_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic [DIV_WIDTH-1:0] quo_o
);
  logic [DIV_WIDTH:0] sh;
  logic [DIV_WIDTH:0] diff;
  logic ge;
  assign sh    = {rem_i, quo_i[DIV_WIDTH-1]};
  assign diff  = sh - {1'b0, div_i};
  assign ge    = sh[DIV_WIDTH] | ~diff[DIV_WIDTH];
  assign rem_o = ge ? diff[DIV_WIDTH-1:0] : sh[DIV_WIDTH-1:0];
  assign quo_o = {quo_i[DIV_WIDTH-2:0], ge};
endmodule

// File: rtl/iter_divider.sv
// iter_divider: 32-bit signed/unsigned iterative restoring divider; ITER_DIVIDER_FAST_EN enables the b=0 / |a|<|b| early exit.
module iter_divider
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder
);
  div_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d, a_q, a_d;
  logic [DIV_WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;
  logic [DIV_WIDTH-1:0] a_mag, b_mag, rem_n, quo_n;
  logic fast;
  div_step u_step (.rem_i(rem_q), .quo_i(quo_q), .div_i(div_q), .rem_o(rem_n), .quo_o(quo_n));
  always_comb begin
    a_mag = mag(a, is_signed);
    b_mag = mag(b, is_signed);
`ifdef ITER_DIVIDER_FAST_EN
    fast = (b == '0) || (a_mag < b_mag);
`else
    fast = 1'b0;
`endif
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    a_d         = a_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    if (state_q == IDLE && start) begin
      a_d     = a;
      rem_d   = '0;
      quo_d   = a_mag;
      div_d   = b_mag;
      cnt_d   = '0;
      qneg_d  = is_signed & (a[DIV_WIDTH-1] ^ b[DIV_WIDTH-1]);
      rneg_d  = is_signed & a[DIV_WIDTH-1];
      dbz_d   = (b == '0);
      state_d = fast ? DONE : RUN;
      busy_d  = ~fast;
      done_d  = fast;
      if (fast) begin
        quotient_d  = (b == '0) ? DIV_DBZ_QUOT : '0;
        remainder_d = a;
      end
    end else if (state_q == RUN) begin
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'(DIV_ITERS - 1)) begin
        state_d     = DONE;
        done_d      = 1'b1;
        quotient_d  = dbz_q ? DIV_DBZ_QUOT : (qneg_q ? -quo_n : quo_n);
        remainder_d = dbz_q ? a_q : (rneg_q ? -rem_n : rem_n);
      end else begin
        busy_d = 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      a_q         <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      a_q         <= a_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: scoreboard bench for iter_divider against an arithmetic reference model.
module tb_iter_divider;
`ifdef ITER_DIVIDER_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] quotient, remainder;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {logic [31:0] q; logic [31:0] r; int c;} exp_t;
  exp_t sb[$];
  logic [31:0] last_q = '0, last_r = '0;
  int op_s = 0, op_lat = 0;
  bit op_active = 1'b0;

  iter_divider dut (.clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .a(a), .b(b),
                    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endfunction

  function automatic longint magl(input logic [31:0] v, input logic s);
    longint x;
    x = s ? longint'($signed(v)) : longint'(v);
    return (x < 0) ? -x : x;
  endfunction

  function automatic void ref_div(input logic [31:0] ia, ib, input logic s, output logic [31:0] q, r);
    longint sa, sb_;
    if (ib == 0) begin
      q = 32'hFFFF_FFFF;
      r = ia;
    end else if (!s) begin
      q = ia / ib;
      r = ia % ib;
    end else begin
      sa  = longint'($signed(ia));
      sb_ = longint'($signed(ib));
      q   = 32'(sa / sb_);
      r   = 32'(sa % sb_);
    end
  endfunction

  function automatic int lat(input logic [31:0] ia, ib, input logic s);
    return (FAST_EN && (ib == 0 || magl(ia, s) < magl(ib, s))) ? 1 : 33;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("busy", 32'(busy), 32'(op_active && op_lat == 33 && cyc > op_s && cyc <= op_s + 32));
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
        else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("done_cycle", 32'(cyc), 32'(e.c));
          last_q = e.q;
          last_r = e.r;
        end
      end else begin
        chk("hold_quotient", quotient, last_q);
        chk("hold_remainder", remainder, last_r);
      end
    end
  end

  // mode 0: plain; 1: extra start in cycle 10; 2: reset in cycle 15
  task automatic issue(input logic [31:0] ia, ib, input logic is, input int mode);
    logic [31:0] eq, er;
    int t;
    @(negedge clk); #1;
    reset = 1'b0;
    ref_div(ia, ib, is, eq, er);
    a = ia; b = ib; is_signed = is; start = 1'b1;
    op_s = cyc; op_lat = lat(ia, ib, is); op_active = 1'b1;
    sb.push_back('{eq, er, cyc + op_lat});
    @(negedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    t = 0;
    while (sb.size() != 0 && t < 80) begin
      if (mode == 1 && cyc == op_s + 10) begin
        start = 1'b1; a = $urandom; b = $urandom | 32'd1;
      end else start = 1'b0;
      if (mode == 2 && cyc == op_s + 15) begin
        reset = 1'b1; sb.delete(); op_active = 1'b0; last_q = '0; last_r = '0;
      end
      @(negedge clk); #1;
      t++;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      chk("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
      op_active = 1'b0;
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_busy"}, 32'(busy), 32'd0);
    chk({n, "_done"}, 32'(done), 32'd0);
    chk({n, "_quotient"}, quotient, 32'd0);
    chk({n, "_remainder"}, remainder, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int sel;
    reset = 1'b1; start = 1'b1; a = 32'h1234; b = 32'd3;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #1 start = 1'b0;
    issue(32'd100, 32'd7, 1'b0, 0);
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, 0);
    issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    issue(32'h1234_5678, 32'd0, 1'b0, 0);
    issue(32'h1234_5678, 32'd0, 1'b1, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    issue(32'd5, 32'd9, 1'b0, 0);
    issue(32'hFFFF_FFFB, 32'd9, 1'b1, 0);
    issue(32'd1000, 32'd33, 1'b0, 1);
    issue(32'hDEAD_BEEF, 32'd17, 1'b1, 2);
    chk_zero("abort");
    issue(32'd12345, 32'd123, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      rb  = (sel == 0) ? 32'd0 :
            (sel <= 3) ? 32'($urandom_range(1, 255)) :
            (sel <= 5) ? $urandom : ($urandom >> $urandom_range(0, 31));
      issue(ra, rb, 1'($urandom), 0);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
